// File: rtl/i2c_slave_regfile_ctrl.sv
// Register-file controller behind an I2C slave's AXI-stream byte ports.
// First byte of each I2C write loads the register pointer, later bytes are stored
// at the pointer with auto-increment, and I2C reads stream from the pointer.
// A host port shares the array; host writes take priority over I2C bytes.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   wr_t*             master-written byte stream (tready = !host_wr_en)
//   rd_t*             byte stream returned to the I2C master
//   bus_addressed     slave currently addressed; low forces pointer phase
//   host_*            host address / write strobe / data / registered read data
//   reg_wr_strobe/addr  pulse + address for each I2C-originated write
//   ptr               current register pointer
module i2c_slave_regfile_ctrl #(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            wr_tdata,
    input  logic                  wr_tvalid,
    output logic                  wr_tready,
    input  logic                  wr_tlast,
    output logic [7:0]            rd_tdata,
    output logic                  rd_tvalid,
    input  logic                  rd_tready,
    input  logic                  bus_addressed,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic                  host_wr_en,
    input  logic [7:0]            host_wr_data,
    output logic [7:0]            host_rd_data,
    output logic                  reg_wr_strobe,
    output logic [ADDR_WIDTH-1:0] reg_wr_addr,
    output logic [ADDR_WIDTH-1:0] ptr
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {
        ST_PTR  = 1'b0,
        ST_DATA = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [7:0]            mem_q [DEPTH];
    logic [7:0]            rd_tdata_q;
    logic                  rd_tvalid_q;
    logic [7:0]            host_rd_data_q;
    logic                  reg_wr_strobe_q;
    logic [ADDR_WIDTH-1:0] reg_wr_addr_q;

    logic                  wr_fire;
    logic                  ptr_load;
    logic                  data_wr;
    logic                  rd_fire;

    // Host writes own the array port; an I2C byte simply waits (SCL stretched).
    assign wr_tready = !host_wr_en;

    // Bytes are only meaningful while addressed; otherwise the FSM idles in PTR.
    assign wr_fire  = wr_tvalid && wr_tready && bus_addressed;
    assign ptr_load = wr_fire && (state_q == ST_PTR);
    assign data_wr  = wr_fire && (state_q == ST_DATA);
    assign rd_fire  = rd_tvalid_q && rd_tready;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;

        if (!bus_addressed) begin
            state_d = ST_PTR;
        end else if (wr_fire) begin
            state_d = wr_tlast ? ST_PTR : ST_DATA;
        end

        // Write-side pointer updates win over a coincident read increment.
        if (ptr_load) begin
            ptr_d = wr_tdata[ADDR_WIDTH-1:0];
        end else if (data_wr) begin
            ptr_d = ptr_q + 1'b1;
        end else if (rd_fire) begin
            ptr_d = ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_PTR;
            ptr_q           <= '0;
            rd_tdata_q      <= 8'h00;
            rd_tvalid_q     <= 1'b0;
            host_rd_data_q  <= 8'h00;
            reg_wr_strobe_q <= 1'b0;
            reg_wr_addr_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;

            if (host_wr_en) begin
                mem_q[host_addr] <= host_wr_data;
            end else if (data_wr) begin
                mem_q[ptr_q] <= wr_tdata;
            end

            reg_wr_strobe_q <= data_wr;
            if (data_wr) begin
                reg_wr_addr_q <= ptr_q;
            end

            // Prefetch at the next pointer so a new pointer is readable at once.
            rd_tdata_q <= mem_q[ptr_d];

            // One bubble after each handshake while the prefetch refreshes.
            rd_tvalid_q <= !rd_fire;

            host_rd_data_q <= mem_q[host_addr];
        end
    end

    assign rd_tdata      = rd_tdata_q;
    assign rd_tvalid     = rd_tvalid_q;
    assign host_rd_data  = host_rd_data_q;
    assign reg_wr_strobe = reg_wr_strobe_q;
    assign reg_wr_addr   = reg_wr_addr_q;
    assign ptr           = ptr_q;

endmodule

// File: tb/tb_i2c_slave_regfile_ctrl.sv
// Bench for i2c_slave_regfile_ctrl: directed scenarios plus random traffic,
// checked every cycle against a transaction-level model of the register file.
module tb_i2c_slave_regfile_ctrl;

    localparam int AW = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    wr_tdata = '0;
    logic          wr_tvalid = 1'b0;
    logic          wr_tready;
    logic          wr_tlast = 1'b0;
    logic [7:0]    rd_tdata;
    logic          rd_tvalid;
    logic          rd_tready = 1'b0;
    logic          bus_addressed = 1'b1;
    logic [AW-1:0] host_addr = '0;
    logic          host_wr_en = 1'b0;
    logic [7:0]    host_wr_data = '0;
    logic [7:0]    host_rd_data;
    logic          reg_wr_strobe;
    logic [AW-1:0] reg_wr_addr;
    logic [AW-1:0] ptr;

    i2c_slave_regfile_ctrl #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_tdata(wr_tdata), .wr_tvalid(wr_tvalid),
        .wr_tready(wr_tready), .wr_tlast(wr_tlast),
        .rd_tdata(rd_tdata), .rd_tvalid(rd_tvalid),
        .rd_tready(rd_tready), .bus_addressed(bus_addressed),
        .host_addr(host_addr), .host_wr_en(host_wr_en),
        .host_wr_data(host_wr_data), .host_rd_data(host_rd_data),
        .reg_wr_strobe(reg_wr_strobe), .reg_wr_addr(reg_wr_addr),
        .ptr(ptr)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Tracks the register contents, the pointer, and whether the next
    // accepted write byte is a pointer byte.
    logic [7:0]    m_mem [DEPTH];
    logic [7:0]    old_mem [DEPTH];
    int            m_ptr;
    bit            m_next_is_ptr;
    logic          m_strobe;
    int            m_waddr;
    logic [7:0]    m_rd_data;
    logic          m_rd_valid;
    logic [7:0]    m_host_rd;
    int            np;
    bit            byte_in;
    bit            read_hs;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            foreach (m_mem[i]) m_mem[i] = 8'h00;
            m_ptr = 0;
            m_next_is_ptr = 1'b1;
            m_strobe = 1'b0;
            m_waddr = 0;
            m_rd_data = 8'h00;
            m_rd_valid = 1'b0;
            m_host_rd = 8'h00;
        end else begin
            old_mem = m_mem;
            np = m_ptr;
            byte_in = wr_tvalid && !host_wr_en && bus_addressed;
            read_hs = m_rd_valid && rd_tready;
            m_strobe = 1'b0;
            m_host_rd = old_mem[host_addr];
            if (host_wr_en) m_mem[host_addr] = host_wr_data;
            if (byte_in) begin
                if (m_next_is_ptr) begin
                    np = wr_tdata % DEPTH;
                end else begin
                    m_mem[m_ptr] = wr_tdata;
                    m_strobe = 1'b1;
                    m_waddr = m_ptr;
                    np = (m_ptr + 1) % DEPTH;
                end
            end else if (read_hs) begin
                np = (m_ptr + 1) % DEPTH;
            end
            if (!bus_addressed) m_next_is_ptr = 1'b1;
            else if (byte_in) m_next_is_ptr = wr_tlast;
            m_ptr = np;
            m_rd_data = old_mem[np];
            m_rd_valid = !read_hs;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("wr_tready", 32'(wr_tready), 32'(!host_wr_en));
            chk("rd_tvalid", 32'(rd_tvalid), 32'(m_rd_valid));
            chk("rd_tdata", 32'(rd_tdata), 32'(m_rd_data));
            chk("host_rd_data", 32'(host_rd_data), 32'(m_host_rd));
            chk("reg_wr_strobe", 32'(reg_wr_strobe), 32'(m_strobe));
            chk("reg_wr_addr", 32'(reg_wr_addr), 32'(m_waddr));
            chk("ptr", 32'(ptr), 32'(m_ptr));
        end
    end

    int sq[$];
    always @(negedge clk) begin
        if (reg_wr_strobe === 1'b1) sq.push_back(int'(reg_wr_addr));
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        int n;
        logic acc;
        n = 0;
        wr_tdata = d;
        wr_tlast = l;
        wr_tvalid = 1'b1;
        do begin
            #1;
            acc = wr_tready;
            step();
            n++;
        end while (!acc && n < 20);
        if (!acc) begin
            n_bad++;
            $display("FAIL send_timeout: got no accept want accept");
        end
        wr_tvalid = 1'b0;
        wr_tlast = 1'b0;
    endtask

    task automatic read_byte(input string nm, input logic [7:0] exp);
        int n;
        n = 0;
        while (rd_tvalid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk({nm, "_valid_wait"}, 32'(rd_tvalid), 32'h1);
        chk(nm, 32'(rd_tdata), 32'(exp));
        rd_tready = 1'b1;
        step();
        rd_tready = 1'b0;
        chk({nm, "_bubble"}, 32'(rd_tvalid), 32'h0);
    endtask

    task automatic hread(input string nm, input logic [AW-1:0] a,
                         input logic [7:0] exp);
        host_addr = a;
        step();
        chk(nm, 32'(host_rd_data), 32'(exp));
    endtask

    initial begin
        step();
        step();
        chk_en = 1'b1;
        chk("reset_rd_tvalid", 32'(rd_tvalid), 32'h0);
        chk("reset_ptr", 32'(ptr), 32'h0);
        rst_n = 1'b1;
        step();
        chk("rd_tvalid_rise", 32'(rd_tvalid), 32'h1);

        // Write 0x03, 0xA5, 0x5A
        sq.delete();
        send(8'h03, 1'b0);
        send(8'hA5, 1'b0);
        send(8'h5A, 1'b1);
        step();
        chk("wr_ptr", 32'(ptr), 32'h5);
        chk("wr_strobe_cnt", 32'(sq.size()), 32'h2);
        if (sq.size() == 2) begin
            chk("wr_strobe_a0", 32'(sq[0]), 32'h3);
            chk("wr_strobe_a1", 32'(sq[1]), 32'h4);
        end
        hread("wr_mem3", 4'd3, 8'hA5);
        hread("wr_mem4", 4'd4, 8'h5A);

        // Pointer-only write then three reads
        send(8'h03, 1'b1);
        step();
        step();
        read_byte("rd0", 8'hA5);
        read_byte("rd1", 8'h5A);
        read_byte("rd2", 8'h00);
        chk("rd_ptr", 32'(ptr), 32'h6);

        // Wrap and masking
        send(8'hFF, 1'b0);
        chk("wrap_ptr_f", 32'(ptr), 32'hF);
        send(8'h11, 1'b0);
        send(8'h22, 1'b1);
        chk("wrap_ptr_1", 32'(ptr), 32'h1);
        hread("wrap_mem15", 4'd15, 8'h11);
        hread("wrap_mem0", 4'd0, 8'h22);

        // Collision at ptr 7
        send(8'h07, 1'b0);
        host_addr = 4'd7;
        host_wr_data = 8'h33;
        host_wr_en = 1'b1;
        wr_tdata = 8'h44;
        wr_tlast = 1'b1;
        wr_tvalid = 1'b1;
        #1;
        chk("col_tready_lo", 32'(wr_tready), 32'h0);
        step();
        chk("col_old_val", 32'(host_rd_data), 32'h00);
        host_wr_en = 1'b0;
        #1;
        chk("col_tready_hi", 32'(wr_tready), 32'h1);
        step();
        wr_tvalid = 1'b0;
        wr_tlast = 1'b0;
        chk("col_mem7_host", 32'(host_rd_data), 32'h33);
        step();
        chk("col_mem7_i2c", 32'(host_rd_data), 32'h44);

        // Abort
        send(8'h02, 1'b0);
        send(8'h10, 1'b0);
        bus_addressed = 1'b0;
        step();
        chk("abort_ptr_hold", 32'(ptr), 32'h3);
        bus_addressed = 1'b1;
        send(8'h08, 1'b0);
        send(8'h20, 1'b1);
        hread("abort_mem2", 4'd2, 8'h10);
        hread("abort_mem8", 4'd8, 8'h20);
        hread("abort_mem3", 4'd3, 8'hA5);

        // Reset mid-write
        send(8'h09, 1'b0);
        send(8'h77, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("rst_rd_tvalid", 32'(rd_tvalid), 32'h0);
        chk("rst_rd_tdata", 32'(rd_tdata), 32'h0);
        chk("rst_host_rd", 32'(host_rd_data), 32'h0);
        chk("rst_strobe", 32'(reg_wr_strobe), 32'h0);
        chk("rst_ptr", 32'(ptr), 32'h0);
        step();
        step();
        rst_n = 1'b1;
        sq.delete();
        send(8'h05, 1'b1);
        step();
        chk("rst_new_ptr", 32'(ptr), 32'h5);
        chk("rst_no_write", 32'(sq.size()), 32'h0);
        hread("rst_mem9", 4'd9, 8'h00);
        hread("rst_mem5", 4'd5, 8'h00);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            bus_addressed = ($urandom_range(0, 19) != 0);
            host_wr_en = ($urandom_range(0, 4) == 0);
            host_addr = AW'($urandom_range(0, DEPTH - 1));
            host_wr_data = 8'($urandom);
            wr_tvalid = bus_addressed && ($urandom_range(0, 2) == 0);
            wr_tdata = 8'($urandom);
            wr_tlast = ($urandom_range(0, 3) == 0);
            rd_tready = bus_addressed && ($urandom_range(0, 2) == 0);
            step();
        end
        wr_tvalid = 1'b0;
        rd_tready = 1'b0;
        host_wr_en = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/i2c_slave_regfile_ctrl.md
# i2c_slave_regfile_ctrl

Register-file controller that sits behind the I2C slave's AXI-stream ports and turns its raw byte streams into addressed register accesses. The first byte of each I2C write sets a register pointer. Later bytes in the same write are stored at the pointer, which then auto-increments. I2C reads return register contents from the pointer onward. A host-side port gives local logic read/write access to the same register array, with defined arbitration.

## Interface
- ADDR_WIDTH, 4, register-array address width; depth is 2^ADDR_WIDTH bytes.
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low; one clock, no other clock domain.
- wr_tdata  in  8  byte from the I2C slave's m_axis_data (master-written byte).
- wr_tvalid  in  1  byte valid.
- wr_tready  out  1  byte accept.
- wr_tlast  in  1  last byte of the I2C write transfer.
- rd_tdata  out  8  byte to the I2C slave's s_axis_data (returned to the I2C master).
- rd_tvalid  out  1  rd_tdata valid.
- rd_tready  in  1  slave accepts the byte.
- bus_addressed  in  1  slave is currently addressed.
- host_addr  in  ADDR_WIDTH  host register address.
- host_wr_en  in  1  host write strobe.
- host_wr_data  in  8  host write data.
- host_rd_data  out  8  mem[host_addr], 1-cycle latency.
- reg_wr_strobe  out  1  one-cycle pulse on each I2C-originated register write.
- reg_wr_addr  out  ADDR_WIDTH  address written at the reg_wr_strobe pulse.
- ptr  out  ADDR_WIDTH  current register pointer.

## Operation
- Register array holds 2^ADDR_WIDTH × 8 bits and is cleared to 0 by reset.
- Write FSM has two states: PTR (reset state) and DATA.
  - PTR, byte accepted: ptr ← wr_tdata[ADDR_WIDTH-1:0] (upper bits ignored). Next state is PTR if wr_tlast is set, otherwise DATA.
  - DATA, byte accepted: mem[ptr] ← wr_tdata, reg_wr_strobe pulses with reg_wr_addr = ptr, then ptr ← ptr+1. Next state is PTR if wr_tlast is set, otherwise DATA.
  - bus_addressed low for any cycle: FSM forced to PTR and ptr is unchanged. This covers aborted writes and release of the bus.
- Pointer arithmetic is modulo 2^ADDR_WIDTH; 2^ADDR_WIDTH−1 increments to 0.
- Read path:
  - rd_tdata register reloads every cycle from mem[ptr_next].
  - Handshake (rd_tvalid && rd_tready): ptr ← ptr+1.
  - rd_tvalid drops for the single cycle after a handshake while rd_tdata refreshes, then returns high.
  - A pointer-only write (one byte with tlast), followed by a repeated-start read, therefore reads from the new pointer.
- Arbitration:
  - Only one array write occurs per cycle.
  - host_wr_en has priority: wr_tready = !host_wr_en (combinational), so an I2C byte waits. The slave stretches SCL while it waits, so no data is lost.
- Host read: host_rd_data ← mem[host_addr], registered. A same-cycle write to that address returns the old value.

## Timing
- Reset values: wr_tready follows !host_wr_en; rd_tvalid 0; rd_tdata 0x00; host_rd_data 0x00; reg_wr_strobe 0; reg_wr_addr 0; ptr 0; state PTR.
- rd_tvalid rises on the first clock after rst_n deasserts.
- I2C write latency: the write is visible in host_rd_data 2 cycles after the wr_tvalid&&wr_tready cycle (1 cycle array write + 1 cycle host read register).
- reg_wr_strobe is asserted the cycle after the accepting handshake.
- A host write, or a pointer change, appears on rd_tdata at most 2 cycles later.
- Pointer update on a read handshake and on a DATA-state write both take effect the next cycle. The two never coincide, because the slave does not run reads and writes concurrently. If they do coincide, the write increment is applied and the read increment is dropped.
- rst_n asserted mid-transfer:
  - Immediately clears the FSM, ptr, the array and the outputs.
  - After release, the next accepted byte is treated as a pointer.

## Test plan
- Write, ADDR_WIDTH=4: bytes 0x03, 0xA5, 0x5A (tlast on 0x5A) → mem[3]=0xA5, mem[4]=0x5A; reg_wr_strobe pulses twice with addresses 3 then 4; ptr=5; state PTR.
- Read: pointer-only write of 0x03 (tlast), then three read handshakes → rd_tdata sequence 0xA5, 0x5A, 0x00; ptr=6; rd_tvalid low exactly one cycle after each handshake.
- Wrap and masking: pointer byte 0xFF, then data 0x11, 0x22 → ptr lands on 0xF; mem[15]=0x11, mem[0]=0x22; ptr=1.
- Collision: host_wr_en=1 (addr 7, data 0x33) in the same cycle as a valid I2C DATA byte 0x44 at ptr 7 → wr_tready=0 that cycle; mem[7] becomes 0x33, then 0x44 on the next cycle; final mem[7]=0x44.
- Abort: pointer 0x02, data 0x10, then bus_addressed low, then new transfer bytes 0x08, 0x20 → mem[2]=0x10, mem[8]=0x20; mem[3] untouched.
- Reset mid-write: rst_n low during the DATA state → all outputs at their reset values while low; after release, byte 0x05 sets ptr=5 with no array write.
